fp_div_seq: RTL and testbench

- Parametrised, iterative (one quotient bit per clock) IEEE-style floating-point divider.
- Successor to the combinational half-precision divider: same binary16 default format, widths now set by EXP_W/MAN_W.
- Start/busy/done handshake and exception flags are new.
- Sits behind the datapath register file; one division in flight at a time.

---
 rtl/fp_div_seq.sv | 182 ++++++++++++++++++
 tb/tb_fp_div_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Iterative floating-point divider: one restoring quotient bit per clock, truncating rounding.
// Fixed MAN_W+4 cycle start-to-done latency; start is ignored while busy or while done is high.
module fp_div_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   q,
    output logic                   div_by_zero,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW2  = EXP_W + 2;
    localparam int QW   = MAN_W + 2;
    localparam int CW   = $clog2(QW + 1);
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX = 2 ** EXP_W - 1;

    localparam logic signed [EW2-1:0] BIAS_E = EW2'(BIAS);
    localparam logic signed [EW2-1:0] EMAX_E = EW2'(EMAX);
    localparam logic signed [EW2-1:0] ZERO_E = '0;
    localparam logic [EXP_W-1:0]      EXP_ONES = '1;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;
    typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

    state_t                 r_state, w_state_nxt;
    spec_t                  r_spec, w_spec;
    logic                   r_sign;
    logic [MAN_W:0]         r_mb;
    logic [QW-1:0]          r_rem;
    logic [QW-1:0]          r_quo;
    logic [CW-1:0]          r_cnt;
    logic signed [EW2-1:0]  r_exp;
    logic [MAN_W-1:0]       r_frac;
    logic [W-1:0]           r_q;
    logic                   r_dz, r_ov, r_uf, r_done;

    logic [EXP_W-1:0]       w_a_exp, w_b_exp;
    logic signed [EW2-1:0]  w_exp_init;
    logic                   w_accept;
    logic                   w_ge;
    logic [QW-1:0]          w_rem_sub;
    logic [W-1:0]           w_res_q;
    logic                   w_res_dz, w_res_ov, w_res_uf;

    assign w_a_exp    = a[W-2:MAN_W];
    assign w_b_exp    = b[W-2:MAN_W];
    assign w_exp_init = {2'b00, w_a_exp} - {2'b00, w_b_exp} + BIAS_E;
    // A request arriving while the previous result is still being announced is dropped.
    assign w_accept   = (r_state == S_IDLE) && start && !r_done;

    always_comb begin
        w_spec = SP_NONE;
        if (w_a_exp == EXP_ONES || w_b_exp == EXP_ONES) begin
            w_spec = SP_NAN;
        end else if (w_a_exp == '0 && w_b_exp == '0) begin
            w_spec = SP_NAN;
        end else if (w_b_exp == '0) begin
            w_spec = SP_INF;
        end else if (w_a_exp == '0) begin
            w_spec = SP_ZERO;
        end
    end

    assign w_ge      = (r_rem >= {1'b0, r_mb});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_DIV;
            S_DIV:  if (r_cnt == CW'(QW - 1)) w_state_nxt = S_NORM;
            S_NORM: w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_res_q  = '0;
        w_res_dz = 1'b0;
        w_res_ov = 1'b0;
        w_res_uf = 1'b0;
        case (r_spec)
            SP_NAN:  w_res_q = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            SP_INF: begin
                w_res_q  = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
                w_res_dz = 1'b1;
            end
            SP_ZERO: w_res_q = {r_sign, {(W-1){1'b0}}};
            default: begin
                if (r_exp >= EMAX_E) begin
                    w_res_q  = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
                    w_res_ov = 1'b1;
                end else if (r_exp <= ZERO_E) begin
                    w_res_q  = {r_sign, {(W-1){1'b0}}};
                    w_res_uf = 1'b1;
                end else begin
                    w_res_q  = {r_sign, r_exp[EXP_W-1:0], r_frac};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_spec <= SP_NONE;
            r_sign <= 1'b0;
            r_mb   <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_exp  <= '0;
            r_frac <= '0;
            r_q    <= '0;
            r_dz   <= 1'b0;
            r_ov   <= 1'b0;
            r_uf   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_spec <= w_spec;
                        r_sign <= a[W-1] ^ b[W-1];
                        r_rem  <= {1'b0, 1'b1, a[MAN_W-1:0]};
                        r_mb   <= {1'b1, b[MAN_W-1:0]};
                        r_exp  <= w_exp_init;
                        r_quo  <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_sub << 1;
                    r_quo <= {r_quo[QW-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_NORM: begin
                    if (r_quo[QW-1]) begin
                        r_frac <= r_quo[MAN_W:1];
                    end else begin
                        r_frac <= r_quo[MAN_W-1:0];
                        r_exp  <= r_exp - 1'b1;
                    end
                end
                S_DONE: begin
                    r_q  <= w_res_q;
                    r_dz <= w_res_dz;
                    r_ov <= w_res_ov;
                    r_uf <= w_res_uf;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign q           = r_q;
    assign div_by_zero = r_dz;
    assign overflow    = r_ov;
    assign underflow   = r_uf;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq at binary16 and binary32 widths, checked against a
// divide-and-classify reference model plus hand-computed literal results.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start16, start32;
    logic [15:0] a16, b16, q16;
    logic [31:0] a32, b32, q32;
    logic        busy16, done16, dz16, ov16, uf16;
    logic        busy32, done32, dz32, ov32, uf32;
    logic [34:0] exp16, exp32;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fp_div_seq #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .reset_n(rst_n), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .q(q16),
        .div_by_zero(dz16), .overflow(ov16), .underflow(uf16)
    );

    fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .reset_n(rst_n), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .q(q32),
        .div_by_zero(dz32), .overflow(ov32), .underflow(uf32)
    );

    // Returns {underflow, overflow, div_by_zero, q zero-extended to 32 bits}.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input int ew, input int mw);
        longint emax  = (64'd1 << ew) - 1;
        longint mmask = (64'd1 << mw) - 1;
        longint bias  = (64'd1 << (ew - 1)) - 1;
        longint ea    = (longint'(a) >> mw) & emax;
        longint eb    = (longint'(b) >> mw) & emax;
        longint sgn   = ((longint'(a) ^ longint'(b)) >> (ew + mw)) & 1;
        longint sbit  = sgn << (ew + mw);
        longint inf   = sbit | (emax << mw);
        longint nan   = (emax << mw) | (64'd1 << (mw - 1));
        longint ma, mb, quo, e, frac, res;
        logic   dz = 1'b0, ov = 1'b0, uf = 1'b0;
        if (ea == emax || eb == emax || (ea == 0 && eb == 0)) begin
            res = nan;
        end else if (eb == 0) begin
            res = inf;
            dz  = 1'b1;
        end else if (ea == 0) begin
            res = sbit;
        end else begin
            ma  = (64'd1 << mw) | (longint'(a) & mmask);
            mb  = (64'd1 << mw) | (longint'(b) & mmask);
            quo = (ma << (mw + 1)) / mb;
            e   = ea - eb + bias;
            if (quo >= (64'd1 << (mw + 1))) begin
                frac = (quo >> 1) & mmask;
            end else begin
                frac = quo & mmask;
                e    = e - 1;
            end
            if (e >= emax) begin
                res = inf;
                ov  = 1'b1;
            end else if (e <= 0) begin
                res = sbit;
                uf  = 1'b1;
            end else begin
                res = sbit | (e << mw) | frac;
            end
        end
        return {uf, ov, dz, res[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done16 === 1'b1) chk("dut16 result vs model", {uf16, ov16, dz16, 16'h0, q16}, exp16);
        if (done32 === 1'b1) chk("dut32 result vs model", {uf32, ov32, dz32, q32}, exp32);
    end

    task automatic op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                      input bit has_lit, input logic [31:0] lit_q, input logic [2:0] lit_f);
        int lat = 0;
        int busy_cnt = 0;
        int want = wide ? 27 : 14;
        @(negedge clk);
        if (wide) begin
            a32 = a; b32 = b; exp32 = model(a, b, 8, 23); start32 = 1'b1;
        end else begin
            a16 = a[15:0]; b16 = b[15:0]; exp16 = model(a, b, 5, 10); start16 = 1'b1;
        end
        @(negedge clk);
        start16 = 1'b0;
        start32 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (wide ? done32 : done16) begin
                lat = k;
                break;
            end
            if (wide ? busy32 : busy16) busy_cnt++;
        end
        chk("latency", lat, want);
        chk("busy cycles before done", busy_cnt, want - 1);
        chk("busy low with done", wide ? busy32 : busy16, 0);
        if (has_lit) begin
            chk("q literal", wide ? q32 : {16'h0, q16}, lit_q);
            chk("flags literal", wide ? {uf32, ov32, dz32} : {uf16, ov16, dz16}, lit_f);
        end
    endtask

    initial begin
        int lat;
        int spurious;
        rst_n = 1'b0;
        start16 = 1'b0; start32 = 1'b0;
        a16 = '0; b16 = '0; a32 = '0; b32 = '0;
        exp16 = '0; exp32 = '0;
        #1;
        chk("reset outputs dut16", {busy16, done16, dz16, ov16, uf16, q16}, 0);
        chk("reset outputs dut32", {busy32, done32, dz32, ov32, uf32, q32}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(0, 32'hCFC2, 32'h3C8F, 1, 32'hCECE, 3'b000);
        op(0, 32'h3C00, 32'h3E00, 1, 32'h3955, 3'b000);
        op(0, 32'h3C00, 32'h3C00, 1, 32'h3C00, 3'b000);
        op(0, 32'h3C00, 32'h0000, 1, 32'h7C00, 3'b001);
        op(0, 32'h0000, 32'h0000, 1, 32'h7E00, 3'b000);
        op(0, 32'h8000, 32'h3C00, 1, 32'h8000, 3'b000);
        op(0, 32'h7BFF, 32'h0400, 1, 32'h7C00, 3'b010);
        op(0, 32'h0400, 32'h7BFF, 1, 32'h0000, 3'b100);
        op(0, 32'h7C00, 32'h3C00, 1, 32'h7E00, 3'b000);
        op(0, 32'hBC00, 32'h3E00, 0, 32'h0, 3'b000);

        // Extra start requests mid-division and in the done cycle must not disturb anything.
        @(negedge clk);
        a16 = 16'hCFC2; b16 = 16'h3C8F; exp16 = model(32'hCFC2, 32'h3C8F, 5, 10); start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin
                a16 = 16'h3C00; b16 = 16'h3E00; start16 = 1'b1;
            end else begin
                start16 = 1'b0;
            end
            @(negedge clk);
            if (done16) begin
                lat = k;
                break;
            end
        end
        start16 = 1'b0;
        chk("latency with ignored starts", lat, 14);
        chk("q with ignored starts", q16, 16'hCECE);
        a16 = 16'h7BFF; b16 = 16'h0400; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        chk("start during done ignored", busy16, 0);
        spurious = 0;
        repeat (30) begin
            @(negedge clk);
            if (done16) spurious++;
        end
        chk("no extra result", spurious, 0);

        // Asynchronous reset in the middle of a division.
        op(0, 32'hCFC2, 32'h3C8F, 0, 32'h0, 3'b000);
        @(negedge clk);
        a16 = 16'h3C00; b16 = 16'h3E00; exp16 = model(32'h3C00, 32'h3E00, 5, 10); start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid-op reset outputs", {busy16, done16, dz16, ov16, uf16, q16}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        op(0, 32'h3C00, 32'h3E00, 1, 32'h3955, 3'b000);

        op(1, 32'hC1F84000, 32'h3F91E000, 0, 32'h0, 3'b000);
        op(1, 32'h3F800000, 32'h3FC00000, 1, 32'h3F2AAAAA, 3'b000);
        op(1, 32'h3F800000, 32'h00000000, 1, 32'h7F800000, 3'b001);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
